// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a single-outstanding valid/ready request into SETUP/ACCESS
// transfers and returns read data and status on a valid/ready response port.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // request port
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB initiator
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Wait counter only needs to reach TIMEOUT-1; TIMEOUT=0 keeps a 1-bit stub.
    localparam int unsigned CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LIMIT      = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                  state_q,       state_d;
    logic                    psel_q,        psel_d;
    logic                    penable_q,     penable_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,       paddr_d;
    logic                    pwrite_q,      pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,      pwdata_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                    rsp_err_q,     rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;

    // State and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_write ? req_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // A ready slave wins over the timeout in the limit cycle.
                if (PREADY) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a transaction-timeline model plus
// a per-cycle compare process, directed scenarios and randomized transfers.
module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // Expected values for the current cycle, set by the driver from the transfer timeline
    logic          chk_en = 1'b0;
    logic          e_psel, e_penable, e_req_ready, e_rsp_valid, e_pwrite;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;
    logic          e_err, e_to;

    // Observations used by the literal pins
    int            n_acc, n_rv;
    logic [DW-1:0] obs_rdata;
    logic          obs_err, obs_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("psel",      32'(PSEL),      32'(e_psel));
            chk("penable",   32'(PENABLE),   32'(e_penable));
            chk("req_ready", 32'(req_ready), 32'(e_req_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            chk("paddr",     PADDR,          e_paddr);
            chk("pwrite",    32'(PWRITE),    32'(e_pwrite));
            chk("pwdata",    PWDATA,         e_pwdata);
            if (e_rsp_valid) begin
                chk("rsp_rdata",   rsp_rdata,         e_rdata);
                chk("rsp_err",     32'(rsp_err),      32'(e_err));
                chk("rsp_timeout", 32'(rsp_timeout),  32'(e_to));
            end
            if (PSEL && PENABLE) n_acc++;
            if (rsp_valid) begin
                n_rv++;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                obs_to    = rsp_timeout;
            end
        end
    end

    task automatic junk_req();
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic set_reset_exp();
        e_psel = 1'b0; e_penable = 1'b0; e_req_ready = 1'b1; e_rsp_valid = 1'b0;
        e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0;
    endtask

    // One transfer: waits = PREADY-low ACCESS cycles before PREADY, hold = rsp_ready-low
    // cycles in RESP, rst_at >= 0 resets in that ACCESS cycle instead of finishing.
    task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int waits, input logic slv, input logic [DW-1:0] rd,
                       input int hold, input int rst_at);
        int  i;
        bit  done;
        n_acc = 0;
        n_rv  = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'($urandom);
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        e_psel = 1'b0; e_penable = 1'b0; e_req_ready = 1'b1; e_rsp_valid = 1'b0;
        @(posedge PCLK); #1;
        // SETUP cycle
        e_req_ready = 1'b0; e_psel = 1'b1; e_penable = 1'b0;
        e_paddr = addr; e_pwrite = wr; e_pwdata = wr ? wdata : '0;
        junk_req();
        rsp_ready = 1'($urandom);
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        @(posedge PCLK); #1;
        // ACCESS cycles
        i = 0;
        done = 1'b0;
        while (!done) begin
            e_penable = 1'b1;
            junk_req();
            if (i == rst_at) begin
                PREADY = 1'b0;
                #2;
                chk_en  = 1'b0;
                PRESETn = 1'b0;
                #1;
                chk("rst_async_psel",      32'(PSEL),      32'd0);
                chk("rst_async_penable",   32'(PENABLE),   32'd0);
                chk("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
                set_reset_exp();
                repeat (2) @(posedge PCLK);
                #1;
                PRESETn = 1'b1;
                req_valid = 1'b0;
                chk_en = 1'b1;
                return;
            end
            if (i == waits) begin
                PREADY = 1'b1; PSLVERR = slv; PRDATA = rd;
                e_rdata = wr ? '0 : rd; e_err = slv; e_to = 1'b0;
                done = 1'b1;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
                if (i == TO - 1) begin
                    e_rdata = '0; e_err = 1'b1; e_to = 1'b1;
                    done = 1'b1;
                end
            end
            @(posedge PCLK); #1;
            i++;
        end
        // RESP cycles
        e_psel = 1'b0; e_penable = 1'b0; e_rsp_valid = 1'b1;
        for (int k = 0; k <= hold; k++) begin
            rsp_ready = (k == hold);
            req_valid = 1'b1; req_addr = $urandom; req_wdata = $urandom;
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
            @(posedge PCLK); #1;
        end
        e_rsp_valid = 1'b0; e_req_ready = 1'b1;
        req_valid = 1'b0; rsp_ready = 1'($urandom);
    endtask

    initial begin
        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
        set_reset_exp();
        #12;
        chk("reset_psel",        32'(PSEL),        32'd0);
        chk("reset_penable",     32'(PENABLE),     32'd0);
        chk("reset_paddr",       PADDR,            32'd0);
        chk("reset_pwdata",      PWDATA,           32'd0);
        chk("reset_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("reset_rsp_rdata",   rsp_rdata,        32'd0);
        chk("reset_rsp_err",     32'(rsp_err),     32'd0);
        chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("reset_req_ready",   32'(req_ready),   32'd1);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        chk_en  = 1'b1;
        @(posedge PCLK); #1;

        // Write, zero wait
        txn(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'hFFFF_FFFF, 0, -1);
        chk("wr0_access_cycles", 32'(n_acc), 32'd1);
        chk("wr0_rdata",         obs_rdata,  32'h0);
        chk("wr0_err",           32'(obs_err), 32'd0);
        chk("wr0_pwdata_held",   PWDATA,     32'hDEAD_BEEF);
        chk("wr0_paddr_held",    PADDR,      32'h0000_0004);

        // Read, 3 wait states
        txn(1'b0, 32'h0000_0008, 32'h1111_1111, 3, 1'b0, 32'h1234_5678, 0, -1);
        chk("rd3_access_cycles", 32'(n_acc),   32'd4);
        chk("rd3_rdata",         obs_rdata,    32'h1234_5678);
        chk("rd3_err",           32'(obs_err), 32'd0);
        chk("rd3_pwdata_zero",   PWDATA,       32'h0);

        // Slave error on read
        txn(1'b0, 32'h0000_000C, 32'h0, 0, 1'b1, 32'hA5A5_A5A5, 0, -1);
        chk("slverr_err",     32'(obs_err), 32'd1);
        chk("slverr_timeout", 32'(obs_to),  32'd0);
        chk("slverr_rdata",   obs_rdata,    32'hA5A5_A5A5);

        // Timeout with PREADY stuck low
        txn(1'b0, 32'h0000_0010, 32'h0, 100, 1'b0, 32'h5555_AAAA, 0, -1);
        chk("to_access_cycles", 32'(n_acc),   32'd4);
        chk("to_err",           32'(obs_err), 32'd1);
        chk("to_timeout",       32'(obs_to),  32'd1);
        chk("to_rdata",         obs_rdata,    32'h0);

        // PREADY in the limit cycle completes normally
        txn(1'b0, 32'h0000_0014, 32'h0, 3, 1'b0, 32'h0BAD_F00D, 0, -1);
        chk("lim_access_cycles", 32'(n_acc),  32'd4);
        chk("lim_timeout",       32'(obs_to), 32'd0);
        chk("lim_rdata",         obs_rdata,   32'h0BAD_F00D);

        // Response backpressure for 5 cycles
        txn(1'b1, 32'h0000_0018, 32'hCAFE_0001, 1, 1'b0, 32'h0, 5, -1);
        chk("bp_rsp_valid_cycles", 32'(n_rv), 32'd6);
        txn(1'b0, 32'h0000_001C, 32'h0, 0, 1'b0, 32'h7777_0000, 0, -1);
        chk("bp_next_rdata", obs_rdata, 32'h7777_0000);

        // Reset during ACCESS wait states
        txn(1'b1, 32'h0000_0020, 32'h1234_0000, 100, 1'b0, 32'h0, 0, 1);
        repeat (3) @(posedge PCLK);
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h0000_0024, 32'h0, 0, 1'b0, 32'h4242_4242, 0, -1);
        chk("post_rst_rdata", obs_rdata, 32'h4242_4242);

        // Randomized transfers
        for (int n = 0; n < 200; n++) begin
            txn(1'($urandom), {$urandom_range(0, 1023), 2'b00}, $urandom,
                int'($urandom_range(0, 6)), 1'($urandom), $urandom,
                int'($urandom_range(0, 3)), -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
